pipelined_mux: RTL

PIPELINED_MUX -- requirements
Module: pipelined_mux

---
 rtl/pipelined_mux.sv | 133 +++++++++++++
 1 files changed

// File: rtl/pipelined_mux.sv
// N-way data selector behind a valid/ready skid buffer.
// Out-of-range selects emit DEFAULT_VALUE, flag sel_err and bump a saturating counter.
module pipelined_mux #(
  parameter int                    DATA_WIDTH    = 12,
  parameter int                    NUM_INPUTS    = 15,
  parameter int                    SELECT_WIDTH  = 4,
  parameter logic [DATA_WIDTH-1:0] DEFAULT_VALUE = '0,
  parameter int                    CNT_WIDTH     = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             i_valid,
  output logic                             o_ready,
  input  logic [SELECT_WIDTH-1:0]          i_select,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] i_data,
  output logic                             o_valid,
  input  logic                             i_ready,
  output logic [DATA_WIDTH-1:0]            o_q,
  output logic                             o_sel_err,
  output logic [CNT_WIDTH-1:0]             o_err_count
);

  if ((2 ** SELECT_WIDTH) < NUM_INPUTS) begin : g_sel_chk
    $error("SELECT_WIDTH too narrow for NUM_INPUTS");
  end
  if (NUM_INPUTS < 2 || NUM_INPUTS > 256) begin : g_num_chk
    $error("NUM_INPUTS out of range 2..256");
  end

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic                    ready_q, ready_d;
  logic [DATA_WIDTH-1:0]   out_q, out_d;
  logic                    oerr_q, oerr_d;
  logic [DATA_WIDTH-1:0]   skid_q, skid_d;
  logic                    serr_q, serr_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;

  logic [DATA_WIDTH-1:0]   mux_val;
  logic                    mux_err;
  logic                    in_fire;
  logic                    out_fire;

  localparam logic [SELECT_WIDTH:0] NUM_SEL = (SELECT_WIDTH+1)'(NUM_INPUTS);

  always_comb begin
    mux_val = DEFAULT_VALUE;
    mux_err = ({1'b0, i_select} >= NUM_SEL);
    for (int k = 0; k < NUM_INPUTS; k++) begin
      if (i_select == SELECT_WIDTH'(k)) begin
        mux_val = i_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign in_fire  = i_valid && ready_q;
  assign out_fire = (state_q != EMPTY) && i_ready;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    oerr_d  = oerr_q;
    skid_d  = skid_q;
    serr_d  = serr_q;
    cnt_d   = cnt_q;
    if (in_fire && mux_err && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
    unique case (state_q)
      EMPTY: begin
        if (in_fire) begin
          out_d   = mux_val;
          oerr_d  = mux_err;
          state_d = ONE;
        end
      end
      ONE: begin
        if (in_fire && !out_fire) begin
          skid_d  = mux_val;
          serr_d  = mux_err;
          state_d = FULL;
        end else if (in_fire && out_fire) begin
          out_d   = mux_val;
          oerr_d  = mux_err;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          out_d   = skid_q;
          oerr_d  = serr_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    // ready is registered so it never depends on i_ready combinationally
    ready_d = (state_d != FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      ready_q <= 1'b0;
      out_q   <= '0;
      oerr_q  <= 1'b0;
      skid_q  <= '0;
      serr_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      out_q   <= out_d;
      oerr_q  <= oerr_d;
      skid_q  <= skid_d;
      serr_q  <= serr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_ready     = ready_q;
  assign o_valid     = (state_q != EMPTY);
  assign o_q         = out_q;
  assign o_sel_err   = oerr_q;
  assign o_err_count = cnt_q;

endmodule
